uart_serial_parity_engine: RTL and testbench
============================================

// Module: uart_serial_parity_engine
// PURPOSE
//  Parity engine for the UART TX/RX paths. Accumulates parity serially, one bit per
//  serializer/deserializer strobe, instead of reducing a parallel word. Supports runtime
//  frame length and five parity modes. In RX use, it also checks a received parity bit
//  and flags mismatches.
// PARAMETERS
//  MAX_WIDTH  8  largest data length in bits; also used when LEN is out of range
//  MIN_WIDTH  5  smallest legal data length in bits
// PORTS
//  CLK         in   1                        system clock, rising edge
//  RST         in   1                        asynchronous active-low reset
//  START       in   1                        1-cycle pulse: new frame; latches LEN and MODE
//  LEN         in   $clog2(MAX_WIDTH+1)      number of data bits in the frame
//  MODE        in   3                        000 none, 001 even, 010 odd, 011 mark, 100 space
//  BIT_EN      in   1                        qualifies BIT_VAL: one data bit (LSB first)
//  BIT_VAL     in   1                        serial data bit
//  PAR_STB     in   1                        received parity bit is present on RX_PAR
//  RX_PAR      in   1                        received parity bit (RX check use)
//  PARITY_BIT  out  1                        computed parity bit, registered
//  PAR_READY   out  1                        PARITY_BIT valid and stable
//  PAR_ERR     out  1                        RX parity mismatch; sticky until next START
//  BUSY        out  1                        frame in progress (state != IDLE)
// BEHAVIOUR
//  - Reset: all outputs 0; state IDLE; accumulator, count and latched config cleared.
//  - States:
//    - IDLE: waits for START.
//    - ACCUM: folds in data bits.
//    - READY: holds the result.
//  - START in any state:
//    - latch LEN and MODE; clear accumulator, bit count and PAR_ERR; drop PAR_READY.
//    - MODE=none: stay in or return to IDLE; nothing else happens.
//    - Reserved MODE 101-111: treated as none.
//    - Any other MODE: go to ACCUM.
//  - LEN < MIN_WIDTH or LEN > MAX_WIDTH: latched as MAX_WIDTH.
//  - ACCUM, each BIT_EN: acc <= acc ^ BIT_VAL; cnt <= cnt + 1.
//    - On the BIT_EN where cnt == LEN-1: go to READY.
//    - At the same edge, register PARITY_BIT:
//      - even: ^bits
//      - odd: ~^bits
//      - mark: 1
//      - space: 0
//    - Latency: PARITY_BIT and PAR_READY are high the cycle after the last BIT_EN.
//  - READY: PAR_READY=1; PARITY_BIT is stable; BIT_EN is ignored.
//    - PAR_STB: PAR_ERR <= (RX_PAR != PARITY_BIT); go to IDLE.
//    - PAR_READY drops and PARITY_BIT holds its value until the next START.
//  - PAR_STB outside READY: ignored; PAR_ERR unchanged.
//  - START together with BIT_EN or PAR_STB in the same cycle: START wins.
//    The bit or strobe is discarded and no error is recorded.
//  - START during ACCUM: aborts the frame; the partial parity is discarded.
//  - RST mid-frame: immediately returns to the reset state; no partial output survives.
//  - cnt width is $clog2(MAX_WIDTH+1); cnt never wraps, because the transition to READY
//    happens at LEN-1.
// STRUCTURE
//  - Shared package uart_pkg holds:
//    - parity mode constants PAR_NONE/EVEN/ODD/MARK/SPACE;
//    - state encoding IDLE/ACCUM/READY;
//    - the MAX/MIN width defaults.
//  - Single module, one FSM plus datapath registers; no sub-module needed.
//  - Mode-to-bit mapping is a local function.
// TESTING
//  1. Reset with all inputs active -> all outputs 0, BUSY 0; release -> still idle.
//  2. LEN=8, even, bits 0xA5 LSB first -> PARITY_BIT=0, PAR_READY 1 cycle after 8th BIT_EN.
//     Same data, odd -> 1.
//  3. LEN=7, odd, bits 0x53 -> PARITY_BIT=1.
//     LEN=3 (illegal), even, 8 bits 0xFF -> READY only after the 8th bit, PARITY_BIT=0.
//  4. Mark and space with 0x00 -> 1 and 0. Mode none + START -> BUSY stays 0, no PAR_READY.
//  5. RX check, even, 0x01: RX_PAR=1 -> PAR_ERR 0; RX_PAR=0 -> PAR_ERR 1, held until START.
//  6. START at 4th bit of a frame -> restart. START+BIT_EN same cycle -> bit dropped.
//     RST mid-ACCUM -> outputs 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity mode codes, parity-engine state encoding and
// default data-width limits.
package uart_pkg;

  localparam int MAX_WIDTH_DEF = 8;
  localparam int MIN_WIDTH_DEF = 5;

  typedef enum logic [2:0] {
    PAR_NONE  = 3'b000,
    PAR_EVEN  = 3'b001,
    PAR_ODD   = 3'b010,
    PAR_MARK  = 3'b011,
    PAR_SPACE = 3'b100
  } par_mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    READY = 2'd2
  } par_state_e;

endpackage

// File: rtl/uart_serial_parity_engine.sv
// Serial parity engine: folds one data bit per strobe into a running XOR, registers
// the final parity bit per mode and optionally checks a received parity bit.
module uart_serial_parity_engine
  import uart_pkg::*;
#(
  parameter int MAX_WIDTH = MAX_WIDTH_DEF,
  parameter int MIN_WIDTH = MIN_WIDTH_DEF
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic                           START,
  input  logic [$clog2(MAX_WIDTH+1)-1:0] LEN,
  input  logic [2:0]                     MODE,
  input  logic                           BIT_EN,
  input  logic                           BIT_VAL,
  input  logic                           PAR_STB,
  input  logic                           RX_PAR,
  output logic                           PARITY_BIT,
  output logic                           PAR_READY,
  output logic                           PAR_ERR,
  output logic                           BUSY
);

  localparam int LW = $clog2(MAX_WIDTH+1);

  par_state_e       state_q, state_d;
  par_mode_e        mode_q, mode_d;
  logic [LW-1:0]    len_q, len_d;
  logic [LW-1:0]    cnt_q, cnt_d;
  logic             acc_q, acc_d;
  logic             parity_q, parity_d;
  logic             err_q, err_d;
  logic             len_legal;

  // Reserved encodings collapse onto PAR_NONE so the FSM only ever sees five modes.
  function automatic par_mode_e decode_mode(input logic [2:0] m);
    case (m)
      3'b001:  return PAR_EVEN;
      3'b010:  return PAR_ODD;
      3'b011:  return PAR_MARK;
      3'b100:  return PAR_SPACE;
      default: return PAR_NONE;
    endcase
  endfunction

  function automatic logic mode_bit(input par_mode_e m, input logic acc);
    case (m)
      PAR_EVEN: return acc;
      PAR_ODD:  return ~acc;
      PAR_MARK: return 1'b1;
      default:  return 1'b0;
    endcase
  endfunction

  assign len_legal = (LEN >= LW'(MIN_WIDTH)) && (LEN <= LW'(MAX_WIDTH));

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    parity_d = parity_q;
    err_d    = err_q;

    if (START) begin
      // START outranks any BIT_EN / PAR_STB arriving in the same cycle.
      len_d    = len_legal ? LEN : LW'(MAX_WIDTH);
      mode_d   = decode_mode(MODE);
      cnt_d    = '0;
      acc_d    = 1'b0;
      parity_d = 1'b0;
      err_d    = 1'b0;
      state_d  = (decode_mode(MODE) == PAR_NONE) ? IDLE : ACCUM;
    end else begin
      case (state_q)
        ACCUM: begin
          if (BIT_EN) begin
            acc_d = acc_q ^ BIT_VAL;
            cnt_d = cnt_q + LW'(1);
            if (cnt_q == len_q - LW'(1)) begin
              parity_d = mode_bit(mode_q, acc_q ^ BIT_VAL);
              state_d  = READY;
            end
          end
        end
        READY: begin
          if (PAR_STB) begin
            err_d   = (RX_PAR != parity_q);
            state_d = IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= IDLE;
      mode_q   <= PAR_NONE;
      len_q    <= '0;
      cnt_q    <= '0;
      acc_q    <= 1'b0;
      parity_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      parity_q <= parity_d;
      err_q    <= err_d;
    end
  end

  assign PARITY_BIT = parity_q;
  assign PAR_READY  = (state_q == READY);
  assign PAR_ERR    = err_q;
  assign BUSY       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_serial_parity_engine.sv
// Bench for the serial parity engine: directed scenarios plus randomized frames
// checked against a popcount-based parity model.
module tb_uart_serial_parity_engine;

  logic       CLK = 1'b0;
  logic       RST;
  logic       START, BIT_EN, BIT_VAL, PAR_STB, RX_PAR;
  logic [3:0] LEN;
  logic [2:0] MODE;
  logic       PARITY_BIT, PAR_READY, PAR_ERR, BUSY;

  int checks = 0;
  int passes = 0;

  uart_serial_parity_engine dut (
    .CLK(CLK), .RST(RST), .START(START), .LEN(LEN), .MODE(MODE),
    .BIT_EN(BIT_EN), .BIT_VAL(BIT_VAL), .PAR_STB(PAR_STB), .RX_PAR(RX_PAR),
    .PARITY_BIT(PARITY_BIT), .PAR_READY(PAR_READY), .PAR_ERR(PAR_ERR), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  // ---------------- reference model ----------------
  function automatic int eff_len(input int l);
    return (l < 5 || l > 8) ? 8 : l;
  endfunction

  function automatic bit mode_active(input int m);
    return (m >= 1 && m <= 4);
  endfunction

  function automatic logic exp_par(input int m, input logic [7:0] d, input int n);
    int ones = 0;
    for (int i = 0; i < n; i++) ones += int'(d[i]);
    case (m)
      1:       return logic'(ones % 2);
      2:       return logic'(1 - (ones % 2));
      3:       return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic start_frame(input int len, input int mode);
    START = 1'b1; LEN = 4'(len); MODE = 3'(mode);
    tick();
    START = 1'b0;
  endtask

  task automatic send_bit(input logic v);
    BIT_EN = 1'b1; BIT_VAL = v;
    tick();
    BIT_EN = 1'b0; BIT_VAL = 1'b0;
  endtask

  task automatic send_bits(input logic [7:0] d, input int from, input int to);
    for (int i = from; i < to; i++) send_bit(d[i]);
  endtask

  task automatic strobe(input logic rx);
    PAR_STB = 1'b1; RX_PAR = rx;
    tick();
    PAR_STB = 1'b0; RX_PAR = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    RST = 1'b0;
    START = 1'b1; LEN = 4'd8; MODE = 3'b001; BIT_EN = 1'b1; BIT_VAL = 1'b1;
    PAR_STB = 1'b1; RX_PAR = 1'b1;
    repeat (3) tick();
    checks++;
    if ({PARITY_BIT, PAR_READY, PAR_ERR, BUSY} !== 4'b0000)
      $display("FAIL reset_outputs got %b exp 0000", {PARITY_BIT, PAR_READY, PAR_ERR, BUSY});
    else passes++;
    START = 1'b0; BIT_EN = 1'b0; BIT_VAL = 1'b0; PAR_STB = 1'b0; RX_PAR = 1'b0;
    tick();
    RST = 1'b1;
    repeat (2) tick();
    checks++;
    if ({PARITY_BIT, PAR_READY, PAR_ERR, BUSY} !== 4'b0000)
      $display("FAIL post_reset_idle got %b exp 0000", {PARITY_BIT, PAR_READY, PAR_ERR, BUSY});
    else passes++;
  endtask

  task automatic test_even_odd();
    start_frame(8, 1);
    send_bits(8'hA5, 0, 7);
    checks++;
    if (PAR_READY !== 1'b0 || BUSY !== 1'b1)
      $display("FAIL even_a5_early ready=%b busy=%b exp ready=0 busy=1", PAR_READY, BUSY);
    else passes++;
    send_bit(1'b1);
    checks++;
    if (PAR_READY !== 1'b1 || PARITY_BIT !== 1'b0)
      $display("FAIL even_a5 ready=%b par=%b exp ready=1 par=0", PAR_READY, PARITY_BIT);
    else passes++;
    start_frame(8, 2);
    send_bits(8'hA5, 0, 8);
    checks++;
    if (PAR_READY !== 1'b1 || PARITY_BIT !== 1'b1)
      $display("FAIL odd_a5 ready=%b par=%b exp ready=1 par=1", PAR_READY, PARITY_BIT);
    else passes++;
  endtask

  task automatic test_len();
    start_frame(7, 2);
    send_bits(8'h53, 0, 7);
    checks++;
    if (PAR_READY !== 1'b1 || PARITY_BIT !== 1'b1)
      $display("FAIL odd_len7_53 ready=%b par=%b exp ready=1 par=1", PAR_READY, PARITY_BIT);
    else passes++;
    start_frame(3, 1);
    send_bits(8'hFF, 0, 3);
    checks++;
    if (PAR_READY !== 1'b0)
      $display("FAIL len3_clamp_early3 ready=%b exp 0", PAR_READY);
    else passes++;
    send_bits(8'hFF, 3, 7);
    checks++;
    if (PAR_READY !== 1'b0)
      $display("FAIL len3_clamp_early7 ready=%b exp 0", PAR_READY);
    else passes++;
    send_bit(1'b1);
    checks++;
    if (PAR_READY !== 1'b1 || PARITY_BIT !== 1'b0)
      $display("FAIL len3_clamp_ff ready=%b par=%b exp ready=1 par=0", PAR_READY, PARITY_BIT);
    else passes++;
  endtask

  task automatic test_mark_space_none();
    start_frame(8, 3);
    send_bits(8'h00, 0, 8);
    checks++;
    if (PAR_READY !== 1'b1 || PARITY_BIT !== 1'b1)
      $display("FAIL mark_00 ready=%b par=%b exp ready=1 par=1", PAR_READY, PARITY_BIT);
    else passes++;
    start_frame(8, 4);
    send_bits(8'h00, 0, 8);
    checks++;
    if (PAR_READY !== 1'b1 || PARITY_BIT !== 1'b0)
      $display("FAIL space_00 ready=%b par=%b exp ready=1 par=0", PAR_READY, PARITY_BIT);
    else passes++;
    start_frame(8, 0);
    checks++;
    if (BUSY !== 1'b0 || PAR_READY !== 1'b0)
      $display("FAIL none_start busy=%b ready=%b exp 0 0", BUSY, PAR_READY);
    else passes++;
    send_bits(8'hFF, 0, 8);
    checks++;
    if (BUSY !== 1'b0 || PAR_READY !== 1'b0)
      $display("FAIL none_bits busy=%b ready=%b exp 0 0", BUSY, PAR_READY);
    else passes++;
    start_frame(8, 6);
    checks++;
    if (BUSY !== 1'b0)
      $display("FAIL reserved_mode busy=%b exp 0", BUSY);
    else passes++;
  endtask

  task automatic test_rx_check();
    start_frame(8, 1);
    send_bits(8'h01, 0, 8);
    strobe(1'b1);
    checks++;
    if (PAR_ERR !== 1'b0 || PAR_READY !== 1'b0 || BUSY !== 1'b0 || PARITY_BIT !== 1'b1)
      $display("FAIL rx_match err=%b ready=%b busy=%b par=%b exp 0 0 0 1",
               PAR_ERR, PAR_READY, BUSY, PARITY_BIT);
    else passes++;
    start_frame(8, 1);
    // strobe during ACCUM is ignored
    PAR_STB = 1'b1; RX_PAR = 1'b0; tick(); PAR_STB = 1'b0;
    checks++;
    if (BUSY !== 1'b1 || PAR_ERR !== 1'b0)
      $display("FAIL stb_in_accum busy=%b err=%b exp 1 0", BUSY, PAR_ERR);
    else passes++;
    send_bits(8'h01, 0, 8);
    strobe(1'b0);
    repeat (3) tick();
    strobe(1'b1);
    checks++;
    if (PAR_ERR !== 1'b1)
      $display("FAIL rx_mismatch_sticky err=%b exp 1", PAR_ERR);
    else passes++;
    start_frame(8, 1);
    checks++;
    if (PAR_ERR !== 1'b0)
      $display("FAIL err_clear_on_start err=%b exp 0", PAR_ERR);
    else passes++;
  endtask

  task automatic test_abort();
    start_frame(8, 1);
    send_bits(8'hFF, 0, 3);
    // restart at 4th bit with the bit on the same cycle; that bit must be dropped
    START = 1'b1; LEN = 4'd5; MODE = 3'b001; BIT_EN = 1'b1; BIT_VAL = 1'b1;
    tick();
    START = 1'b0; BIT_EN = 1'b0; BIT_VAL = 1'b0;
    send_bits(8'h01, 0, 4);
    checks++;
    if (PAR_READY !== 1'b0)
      $display("FAIL start_bit_dropped ready=%b exp 0", PAR_READY);
    else passes++;
    send_bit(1'b0);
    checks++;
    if (PAR_READY !== 1'b1 || PARITY_BIT !== 1'b1)
      $display("FAIL restart_result ready=%b par=%b exp 1 1", PAR_READY, PARITY_BIT);
    else passes++;
    start_frame(8, 2);
    send_bits(8'h0F, 0, 5);
    #2 RST = 1'b0;
    #1;
    checks++;
    if ({PARITY_BIT, PAR_READY, PAR_ERR, BUSY} !== 4'b0000)
      $display("FAIL rst_mid_accum got %b exp 0000", {PARITY_BIT, PAR_READY, PAR_ERR, BUSY});
    else passes++;
    tick(); RST = 1'b1; tick();
    start_frame(8, 2);
    send_bits(8'h00, 0, 8);
    #2 RST = 1'b0;
    #1;
    checks++;
    if ({PARITY_BIT, PAR_READY, PAR_ERR, BUSY} !== 4'b0000)
      $display("FAIL rst_in_ready got %b exp 0000", {PARITY_BIT, PAR_READY, PAR_ERR, BUSY});
    else passes++;
    tick(); RST = 1'b1; tick();
  endtask

  task automatic test_back_to_back();
    start_frame(6, 2);
    send_bits(8'h3F, 0, 6);
    // START beats a mismatching strobe in READY: no error recorded
    START = 1'b1; LEN = 4'd8; MODE = 3'b001; PAR_STB = 1'b1; RX_PAR = 1'b0;
    tick();
    START = 1'b0; PAR_STB = 1'b0;
    checks++;
    if (PAR_ERR !== 1'b0 || BUSY !== 1'b1 || PAR_READY !== 1'b0)
      $display("FAIL b2b_start_wins err=%b busy=%b ready=%b exp 0 1 0", PAR_ERR, BUSY, PAR_READY);
    else passes++;
    send_bits(8'h07, 0, 8);
    checks++;
    if (PAR_READY !== 1'b1 || PARITY_BIT !== 1'b1)
      $display("FAIL b2b_second ready=%b par=%b exp 1 1", PAR_READY, PARITY_BIT);
    else passes++;
  endtask

  task automatic test_random();
    for (int f = 0; f < 60; f++) begin
      int          len  = int'($urandom_range(0, 15));
      int          mode = int'($urandom_range(0, 7));
      logic [7:0]  d    = 8'($urandom);
      int          n    = eff_len(len);
      logic        ep   = exp_par(mode, d, n);
      logic        rx   = 1'($urandom);
      start_frame(len, mode);
      if (!mode_active(mode)) begin
        checks++;
        if (BUSY !== 1'b0 || PAR_READY !== 1'b0)
          $display("FAIL rand_none f=%0d mode=%0d busy=%b ready=%b exp 0 0", f, mode, BUSY, PAR_READY);
        else passes++;
      end else begin
        for (int i = 0; i < n; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            BIT_VAL = 1'($urandom);
            tick();
          end
          send_bit(d[i]);
          if (i == n - 2) begin
            checks++;
            if (PAR_READY !== 1'b0 || BUSY !== 1'b1)
              $display("FAIL rand_early f=%0d len=%0d ready=%b busy=%b exp 0 1", f, len, PAR_READY, BUSY);
            else passes++;
          end
        end
        checks++;
        if (PAR_READY !== 1'b1 || PARITY_BIT !== ep)
          $display("FAIL rand_par f=%0d len=%0d mode=%0d d=%h ready=%b par=%b exp 1 %b",
                   f, len, mode, d, PAR_READY, PARITY_BIT, ep);
        else passes++;
        strobe(rx);
        checks++;
        if (PAR_ERR !== (rx != ep) || BUSY !== 1'b0 || PARITY_BIT !== ep)
          $display("FAIL rand_rx f=%0d err=%b busy=%b par=%b exp %b 0 %b",
                   f, PAR_ERR, BUSY, PARITY_BIT, (rx != ep), ep);
        else passes++;
      end
    end
  endtask

  initial begin
    RST = 1'b0; START = 1'b0; LEN = '0; MODE = '0;
    BIT_EN = 1'b0; BIT_VAL = 1'b0; PAR_STB = 1'b0; RX_PAR = 1'b0;
    test_reset();
    test_even_odd();
    test_len();
    test_mark_space_none();
    test_rx_check();
    test_abort();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
